instr_fetch: RTL

//  Fetch stage feeding decode. Generates the 13-bit word address into instruction memory and

---
 rtl/instr_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: drives instruction-memory address, captures instr+PC
// into a prefetch queue for decode; handles redirect flush and halt.
module instr_fetch #(
    parameter int          DEPTH  = 4,
    parameter logic [19:0] NOP    = 20'h0,
    parameter logic [12:0] RST_PC = 13'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] im_addr,
    input  logic [19:0] im_instr,
    input  logic        stall_ID,
    input  logic        redirect,
    input  logic [12:0] redirect_pc,
    input  logic        hlt,
    output logic        id_vld,
    output logic [19:0] id_instr,
    output logic [12:0] id_pc,
    output logic [12:0] id_pc_inc,
    output logic        halted
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t state, state_nxt;

    logic [12:0]   fetch_pc;
    logic [12:0]   q_pc    [DEPTH];
    logic [19:0]   q_instr [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic run, flush, push, pop;

    assign im_addr = fetch_pc;
    assign halted  = (state == HALT);

    always_comb begin
        run   = (state == RUN);
        flush = run && redirect && !hlt;
        pop   = id_vld && !stall_ID && !flush;
        push  = run && !redirect && !hlt && ((count < FULL) || pop);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (hlt) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            fetch_pc <= RST_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 13'd1;
                    wr_ptr   <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop) begin
                    count <= count + (AW + 1)'(1);
                end else if (!push && pop) begin
                    count <= count - (AW + 1)'(1);
                end
            end
        end
    end

    // When full with a pop, wr_ptr == rd_ptr: head is read before overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= NOP;
            end
        end else if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= im_instr;
        end
    end

    always_comb begin
        id_vld    = (count != '0);
        id_instr  = id_vld ? q_instr[rd_ptr] : NOP;
        id_pc     = id_vld ? q_pc[rd_ptr] : '0;
        id_pc_inc = id_pc + 13'd1;
    end

endmodule
